// File: rtl/dequantization_stream.sv
// Row-at-a-time JPEG luminance dequantizer between zigzag reorder and the IDCT.
// One output register with valid/ready on both sides; tracks the row index within each 8x8 block.
module dequantization_stream #(
    parameter int unsigned IN_W  = 10,
    parameter int unsigned OUT_W = 12
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [8*IN_W-1:0]    in_data,
    input  logic                 in_valid,
    input  logic                 in_first,
    output logic                 in_ready,
    output logic [8*OUT_W-1:0]   out_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2:0]           out_row,
    output logic                 out_last,
    output logic                 out_sat
);

    localparam int unsigned PW = IN_W + 8;

    // Row 0 col 0 in the MSBs, row 7 col 7 in the LSBs.
    localparam logic [64*7-1:0] Q_TABLE = {
        7'd16, 7'd11, 7'd10, 7'd16, 7'd24,  7'd40,  7'd51,  7'd61,
        7'd12, 7'd12, 7'd14, 7'd19, 7'd26,  7'd58,  7'd60,  7'd55,
        7'd14, 7'd13, 7'd16, 7'd24, 7'd40,  7'd57,  7'd69,  7'd56,
        7'd14, 7'd17, 7'd22, 7'd29, 7'd51,  7'd87,  7'd80,  7'd62,
        7'd18, 7'd22, 7'd37, 7'd56, 7'd68,  7'd109, 7'd103, 7'd77,
        7'd24, 7'd35, 7'd55, 7'd64, 7'd81,  7'd104, 7'd113, 7'd92,
        7'd49, 7'd64, 7'd78, 7'd87, 7'd103, 7'd121, 7'd120, 7'd101,
        7'd72, 7'd92, 7'd95, 7'd98, 7'd112, 7'd100, 7'd103, 7'd99
    };

    localparam logic signed [PW-1:0] SAT_MAX = PW'((2 ** (OUT_W - 1)) - 1);
    localparam logic signed [PW-1:0] SAT_MIN = ~SAT_MAX;

    logic                 r_valid;
    logic [8*OUT_W-1:0]   r_data;
    logic [2:0]           r_row;
    logic                 r_last;
    logic                 r_sat;
    logic [2:0]           r_row_cnt;

    logic                 w_accept;
    logic [2:0]           w_eff_row;
    logic [6:0]           w_q;
    logic signed [PW-1:0] w_x;
    logic signed [PW-1:0] w_qs;
    logic signed [PW-1:0] w_prod;
    logic [8*OUT_W-1:0]   w_coef;
    logic                 w_sat;

    assign in_ready  = !r_valid || out_ready;
    assign w_accept  = in_valid && in_ready;
    assign w_eff_row = in_first ? 3'd0 : r_row_cnt;

    always_comb begin
        w_coef = '0;
        w_sat  = 1'b0;
        w_q    = '0;
        w_x    = '0;
        w_qs   = '0;
        w_prod = '0;
        for (int c = 0; c < 8; c++) begin
            w_q    = Q_TABLE[(63 - (int'(w_eff_row) * 8 + c)) * 7 +: 7];
            w_x    = PW'($signed(in_data[(7 - c) * IN_W +: IN_W]));
            w_qs   = PW'({1'b0, w_q});
            w_prod = w_x * w_qs;
            if (w_prod > SAT_MAX) begin
                w_coef[(7 - c) * OUT_W +: OUT_W] = SAT_MAX[OUT_W-1:0];
                w_sat = 1'b1;
            end else if (w_prod < SAT_MIN) begin
                w_coef[(7 - c) * OUT_W +: OUT_W] = SAT_MIN[OUT_W-1:0];
                w_sat = 1'b1;
            end else begin
                w_coef[(7 - c) * OUT_W +: OUT_W] = w_prod[OUT_W-1:0];
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_valid   <= 1'b0;
            r_data    <= '0;
            r_row     <= 3'd0;
            r_last    <= 1'b0;
            r_sat     <= 1'b0;
            r_row_cnt <= 3'd0;
        end else if (w_accept) begin
            r_valid   <= 1'b1;
            r_data    <= w_coef;
            r_row     <= w_eff_row;
            r_last    <= (w_eff_row == 3'd7);
            r_sat     <= w_sat;
            r_row_cnt <= w_eff_row + 3'd1;
        end else if (out_ready) begin
            r_valid   <= 1'b0;
        end
    end

    assign out_valid = r_valid;
    assign out_data  = r_data;
    assign out_row   = r_row;
    assign out_last  = r_last;
    assign out_sat   = r_sat;

endmodule
